// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file.
package regfile_pkg;

   localparam int unsigned REGFILE_WIDTH  = 16;
   localparam int unsigned REGFILE_DEPTH  = 8;
   localparam int unsigned REGFILE_PC_INC = 1;
   localparam int unsigned REGFILE_AW     = $clog2(REGFILE_DEPTH);

   typedef logic [REGFILE_AW-1:0]    regfile_addr_t;
   typedef logic [REGFILE_WIDTH-1:0] regfile_data_t;

   // True when addr selects register 0 and the hardwired zero register is enabled.
   function automatic bit is_zero_reg(input bit zero_en, input logic [31:0] addr);
      return zero_en && (addr == 32'd0);
   endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Decode/writeback bus of the register file: write port, two read ports, PC and scoreboard.
interface regfile_param_if
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = REGFILE_WIDTH,
   parameter int unsigned AW    = REGFILE_AW
);

   logic             regen;
   logic [AW-1:0]    inaddr;
   logic [WIDTH-1:0] in;
   logic [AW-1:0]    outaddr1;
   logic [AW-1:0]    outaddr2;
   logic [WIDTH-1:0] out1;
   logic [WIDTH-1:0] out2;
   logic [WIDTH-1:0] pcout;
   logic             pcinc;
   logic             busy_set;
   logic [AW-1:0]    busy_addr;
   logic             busy1;
   logic             busy2;

   modport master (
      output regen, inaddr, in, outaddr1, outaddr2, pcinc, busy_set, busy_addr,
      input  out1, out2, pcout, busy1, busy2
   );

   modport slave (
      input  regen, inaddr, in, outaddr1, outaddr2, pcinc, busy_set, busy_addr,
      output out1, out2, pcout, busy1, busy2
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: set by issue, cleared by writeback, set wins on collision.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH   = REGFILE_DEPTH,
   parameter int unsigned ZERO_R0 = 0,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] query1,
   input  logic [AW-1:0] query2,
   output logic          busy1_c,
   output logic          busy2_c
);

   localparam bit ZERO_EN = (ZERO_R0 != 0);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic             set_ok;
   logic             clr_ok;

   always_comb begin
      set_ok = set_en && !is_zero_reg(ZERO_EN, 32'(set_addr));
      clr_ok = clr_en && !is_zero_reg(ZERO_EN, 32'(clr_addr));
   end

   // Clear first so a same-address set (new producer) overrides it.
   always_comb begin
      busy_next = busy;
      if (clr_ok) busy_next[clr_addr] = 1'b0;
      if (set_ok) busy_next[set_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_next;
   end

   always_comb begin
      busy1_c = is_zero_reg(ZERO_EN, 32'(query1)) ? 1'b0 : busy[query1];
      busy2_c = is_zero_reg(ZERO_EN, 32'(query2)) ? 1'b0 : busy[query2];
   end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file; top register is the auto-incrementing PC.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to out1/out2/pcout.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH   = REGFILE_WIDTH,
   parameter int unsigned DEPTH   = REGFILE_DEPTH,
   parameter int unsigned AW      = $clog2(DEPTH),
   parameter int unsigned PC_INC  = REGFILE_PC_INC,
   parameter int unsigned ZERO_R0 = 0
) (
   input  logic          clk,
   input  logic          rst,
   regfile_param_if.slave bus
);

   localparam bit               ZERO_EN  = (ZERO_R0 != 0);
   localparam logic [AW-1:0]    PC_ADDR  = AW'(DEPTH - 1);
   localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(PC_INC);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_en;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;

   // Writes to a hardwired zero register are dropped entirely.
   always_comb begin
      wr_en = bus.regen && !is_zero_reg(ZERO_EN, 32'(bus.inaddr));
   end

   // PC increment is scheduled first so a same-cycle write to the PC overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (bus.pcinc) regs[PC_ADDR] <= regs[PC_ADDR] + PC_STEP;
         if (wr_en)     regs[bus.inaddr] <= bus.in;
      end
   end

   always_comb begin
      rd1 = is_zero_reg(ZERO_EN, 32'(bus.outaddr1)) ? '0 : regs[bus.outaddr1];
      rd2 = is_zero_reg(ZERO_EN, 32'(bus.outaddr2)) ? '0 : regs[bus.outaddr2];
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      bus.out1  = (wr_en && (bus.inaddr == bus.outaddr1)) ? bus.in : rd1;
      bus.out2  = (wr_en && (bus.inaddr == bus.outaddr2)) ? bus.in : rd2;
      bus.pcout = (wr_en && (bus.inaddr == PC_ADDR))      ? bus.in : regs[PC_ADDR];
   end
`else
   always_comb begin
      bus.out1  = rd1;
      bus.out2  = rd2;
      bus.pcout = regs[PC_ADDR];
   end
`endif

   regfile_scoreboard #(
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (bus.busy_set),
      .set_addr (bus.busy_addr),
      .clr_en   (bus.regen),
      .clr_addr (bus.inaddr),
      .query1   (bus.outaddr1),
      .query2   (bus.outaddr2),
      .busy1_c  (bus.busy1),
      .busy2_c  (bus.busy2)
   );

endmodule
